// File: rtl/c7bifu_pkg.sv
// Shared definitions for the c7bifu fetch-control slice: prefetch address-select
// indices and the counter-width helper.
package c7bifu_pkg;

  localparam int SEL_INIT = 0;
  localparam int SEL_OLD  = 1;
  localparam int SEL_INC  = 2;
  localparam int SEL_BRN  = 3;
  localparam int SEL_ISR  = 4;
  localparam int SEL_ERT  = 5;
  localparam int SEL_NUM  = 6;

  // Bits needed to hold 0..max_out inclusive.
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/c7bifu_fcl_mo_if.sv
// Fetch-control bundle: ICU request/response handshake, EXU redirects,
// IQ credits and the prefetch address-mux controls.
interface c7bifu_fcl_mo_if
  import c7bifu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int IQ_DEPTH        = 4
);
  localparam int CNT_W    = cnt_w(MAX_OUTSTANDING);
  localparam int IQ_CNT_W = $clog2(IQ_DEPTH + 1);

  logic                ifu_icu_req_ic1;
  logic                icu_ifu_ack_ic1;
  logic                icu_ifu_data_valid_ic2;
  logic                exu_ifu_except;
  logic                exu_ifu_branch;
  logic                exu_ifu_ertn;
  logic                exu_ifu_stall;
  logic [IQ_CNT_W-1:0] iq_free;
  logic                pf_addr_sel_init;
  logic                pf_addr_sel_old;
  logic                pf_addr_sel_inc;
  logic                pf_addr_sel_brn;
  logic                pf_addr_sel_isr;
  logic                pf_addr_sel_ert;
  logic                pf_addr_en;
  logic                icu_data_vld;
  logic                stall;
  logic                flush;
  logic [CNT_W-1:0]    outst_cnt;

  // Fetch-control side.
  modport master (
    input  icu_ifu_ack_ic1, icu_ifu_data_valid_ic2,
           exu_ifu_except, exu_ifu_branch, exu_ifu_ertn, exu_ifu_stall, iq_free,
    output ifu_icu_req_ic1,
           pf_addr_sel_init, pf_addr_sel_old, pf_addr_sel_inc,
           pf_addr_sel_brn, pf_addr_sel_isr, pf_addr_sel_ert,
           pf_addr_en, icu_data_vld, stall, flush, outst_cnt
  );

  // ICU / EXU / IQ side.
  modport slave (
    output icu_ifu_ack_ic1, icu_ifu_data_valid_ic2,
           exu_ifu_except, exu_ifu_branch, exu_ifu_ertn, exu_ifu_stall, iq_free,
    input  ifu_icu_req_ic1,
           pf_addr_sel_init, pf_addr_sel_old, pf_addr_sel_inc,
           pf_addr_sel_brn, pf_addr_sel_isr, pf_addr_sel_ert,
           pf_addr_en, icu_data_vld, stall, flush, outst_cnt
  );

endinterface

// File: rtl/c7bifu_dff.sv
// Codebase flop cells: async active-low reset to zero, with and without load enable.
module dffrl_ns #(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [SIZE-1:0] din,
  output logic [SIZE-1:0] q
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) q <= '0;
    else        q <= din;
  end

endmodule

module dffrle_ns #(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            en,
  input  logic [SIZE-1:0] din,
  output logic [SIZE-1:0] q
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)  q <= '0;
    else if (en) q <= din;
  end

endmodule

// File: rtl/c7bifu_updn_cnt.sv
// Saturating up/down counter with synchronous load; exposes its next value so
// callers can make same-cycle decisions on it.
module c7bifu_updn_cnt #(
  parameter int W   = 2,
  parameter int MAX = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         up,
  input  logic         dn,
  output logic [W-1:0] cnt_nxt,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic en;

  // NOTE: default first so every path assigns cnt_nxt and no latch is inferred.
  always_comb begin
    cnt_nxt = cnt;
    if (load) begin
      cnt_nxt = load_val;
    end else if (up && !dn) begin
      if (cnt != MAX_C) cnt_nxt = cnt + W'(1);
    end else if (dn && !up) begin
      if (cnt != '0) cnt_nxt = cnt - W'(1);
    end
  end

  assign en = load | (up ^ dn);

  dffrle_ns #(.SIZE(W)) u_q (
    .clk   (clk),
    .rst_l (resetn),
    .en    (en),
    .din   (cnt_nxt),
    .q     (cnt)
  );

endmodule

// File: rtl/c7bifu_fcl_mo.sv
// Multi-outstanding ICU fetch control: issues under outstanding/credit limits,
// redirects on except/ertn/branch and drops responses made stale by a flush.
module c7bifu_fcl_mo
  import c7bifu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int IQ_DEPTH        = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  c7bifu_fcl_mo_if.master      bus
);

  localparam int               CNT_W   = cnt_w(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic               rst_done;
  logic               req_q;
  logic               req_nxt;
  logic               issue;
  logic               ack;
  logic               valid;
  logic               flush;
  logic [CNT_W-1:0]   out_cnt;
  logic [CNT_W-1:0]   out_nxt;
  logic [CNT_W-1:0]   cancel_cnt;
  logic [CNT_W-1:0]   cancel_nxt;
  logic [CNT_W-1:0]   live_nxt;
  logic [SEL_NUM-1:0] sel;

  assign ack   = bus.icu_ifu_ack_ic1;
  assign valid = bus.icu_ifu_data_valid_ic2;
  assign flush = bus.exu_ifu_except | bus.exu_ifu_branch | bus.exu_ifu_ertn;

  dffrl_ns #(.SIZE(1)) u_rst_done (
    .clk   (clk),
    .rst_l (resetn),
    .din   (1'b1),
    .q     (rst_done)
  );

  c7bifu_updn_cnt #(.W(CNT_W), .MAX(MAX_OUTSTANDING)) u_out_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (1'b0),
    .load_val ('0),
    .up       (ack),
    .dn       (valid),
    .cnt_nxt  (out_nxt),
    .cnt      (out_cnt)
  );

  // A flush marks everything still in flight after this edge as stale, including
  // a fetch acked this cycle (it used the old address); a beat returning this
  // cycle is already excluded because out_nxt subtracts it.
  c7bifu_updn_cnt #(.W(CNT_W), .MAX(MAX_OUTSTANDING)) u_cancel_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (flush),
    .load_val (out_nxt),
    .up       (1'b0),
    .dn       (valid),
    .cnt_nxt  (cancel_nxt),
    .cnt      (cancel_cnt)
  );

  // Stale beats hold an outstanding slot but never consume an IQ entry.
  assign live_nxt = (out_nxt > cancel_nxt) ? (out_nxt - cancel_nxt) : '0;

  assign issue = rst_done
               & ~(req_q & ~ack)
               & (out_nxt < MAX_CNT)
               & (int'(bus.iq_free) > int'(live_nxt));

  // An unacked request stays up across a redirect: the ICU samples the address at ack.
  assign req_nxt = (req_q & ~ack) | issue;

  dffrl_ns #(.SIZE(1)) u_req (
    .clk   (clk),
    .rst_l (resetn),
    .din   (req_nxt),
    .q     (req_q)
  );

  always_comb begin
    sel = '0;
    if (!rst_done)              sel[SEL_INIT] = 1'b1;
    else if (bus.exu_ifu_except) sel[SEL_ISR] = 1'b1;
    else if (bus.exu_ifu_ertn)   sel[SEL_ERT] = 1'b1;
    else if (bus.exu_ifu_branch) sel[SEL_BRN] = 1'b1;
    else if (ack)                sel[SEL_INC] = 1'b1;
    else                         sel[SEL_OLD] = 1'b1;
  end

  assign bus.pf_addr_sel_init = sel[SEL_INIT];
  assign bus.pf_addr_sel_old  = sel[SEL_OLD];
  assign bus.pf_addr_sel_inc  = sel[SEL_INC];
  assign bus.pf_addr_sel_brn  = sel[SEL_BRN];
  assign bus.pf_addr_sel_isr  = sel[SEL_ISR];
  assign bus.pf_addr_sel_ert  = sel[SEL_ERT];
  assign bus.pf_addr_en       = sel[SEL_INIT] | flush | sel[SEL_INC];

  assign bus.ifu_icu_req_ic1  = req_q;
  assign bus.icu_data_vld     = valid & (cancel_cnt == '0) & ~flush;
  assign bus.stall            = bus.exu_ifu_stall;
  assign bus.flush            = flush;
  assign bus.outst_cnt        = out_cnt;

  // Protocol errors: the counters saturate, these flag the offending cycle.
  a_valid_underflow: assert property (@(posedge clk) disable iff (!resetn)
    !(valid && out_cnt == '0));
  a_ack_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(ack && out_cnt == MAX_CNT));

endmodule

// File: tb/tb_c7bifu_fcl_mo.sv
// Directed, table-driven bench for c7bifu_fcl_mo with MAX_OUTSTANDING=2, IQ_DEPTH=4.
module tb_c7bifu_fcl_mo;
  import c7bifu_pkg::*;

  localparam int MAXO = 2;
  localparam int IQD  = 4;
  localparam int NROW = 27;

  localparam logic [5:0] S_INIT = 6'(1 << SEL_INIT);
  localparam logic [5:0] S_OLD  = 6'(1 << SEL_OLD);
  localparam logic [5:0] S_INC  = 6'(1 << SEL_INC);
  localparam logic [5:0] S_BRN  = 6'(1 << SEL_BRN);
  localparam logic [5:0] S_ISR  = 6'(1 << SEL_ISR);
  localparam logic [5:0] S_ERT  = 6'(1 << SEL_ERT);

  typedef struct {
    logic       ack, valid, exc, brn, ert, stl;
    logic [2:0] iq;
    logic       req;
    logic [1:0] outst;
    logic       vld;
    logic [5:0] sel;
    logic       en, fl;
  } vec_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[NROW];

  always #5 clk = ~clk;

  c7bifu_fcl_mo_if #(.MAX_OUTSTANDING(MAXO), .IQ_DEPTH(IQD)) bus ();

  c7bifu_fcl_mo #(.MAX_OUTSTANDING(MAXO), .IQ_DEPTH(IQD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  function automatic vec_t mk(input logic ack, valid, exc, brn, ert, stl,
                              input logic [2:0] iq, input logic req,
                              input logic [1:0] outst, input logic vld,
                              input logic [5:0] sel, input logic en, fl);
    vec_t v;
    v.ack = ack; v.valid = valid; v.exc = exc; v.brn = brn; v.ert = ert;
    v.stl = stl; v.iq = iq; v.req = req; v.outst = outst; v.vld = vld;
    v.sel = sel; v.en = en; v.fl = fl;
    return v;
  endfunction

  function automatic logic [5:0] sel_act();
    logic [5:0] s;
    s = '0;
    s[SEL_INIT] = bus.pf_addr_sel_init;
    s[SEL_OLD]  = bus.pf_addr_sel_old;
    s[SEL_INC]  = bus.pf_addr_sel_inc;
    s[SEL_BRN]  = bus.pf_addr_sel_brn;
    s[SEL_ISR]  = bus.pf_addr_sel_isr;
    s[SEL_ERT]  = bus.pf_addr_sel_ert;
    return s;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.icu_ifu_ack_ic1        = v.ack;
    bus.icu_ifu_data_valid_ic2 = v.valid;
    bus.exu_ifu_except         = v.exc;
    bus.exu_ifu_branch         = v.brn;
    bus.exu_ifu_ertn           = v.ert;
    bus.exu_ifu_stall          = v.stl;
    bus.iq_free                = v.iq;
  endtask

  task automatic drive_idle();
    drive(mk(0,0,0,0,0,0, 3'd4, 0,2'd0,0,S_OLD,0,0));
  endtask

  // Drive a row just after a rising edge, compare on the following falling edge.
  task automatic run_row(input int i);
    @(posedge clk);
    #1;
    drive(tbl[i]);
    @(negedge clk);
    check("req",   i, 32'(bus.ifu_icu_req_ic1), 32'(tbl[i].req));
    check("outst", i, 32'(bus.outst_cnt),       32'(tbl[i].outst));
    check("vld",   i, 32'(bus.icu_data_vld),    32'(tbl[i].vld));
    check("sel",   i, 32'(sel_act()),           32'(tbl[i].sel));
    check("en",    i, 32'(bus.pf_addr_en),      32'(tbl[i].en));
    check("flush", i, 32'(bus.flush),           32'(tbl[i].fl));
    check("stall", i, 32'(bus.stall),           32'(tbl[i].stl));
  endtask

  task automatic check_reset(input int tag);
    check("rst_req",   tag, 32'(bus.ifu_icu_req_ic1), 32'(0));
    check("rst_outst", tag, 32'(bus.outst_cnt),       32'(0));
    check("rst_vld",   tag, 32'(bus.icu_data_vld),    32'(0));
    check("rst_sel",   tag, 32'(sel_act()),           32'(S_INIT));
    check("rst_en",    tag, 32'(bus.pf_addr_en),      32'(1));
    check("rst_flush", tag, 32'(bus.flush),           32'(0));
  endtask

  initial begin
    //            ack val exc brn ert stl iq     req out vld sel     en fl
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 3'd4,  0, 2'd0, 0, S_OLD, 0, 0); // rst_done up, issue
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 3'd4,  1, 2'd0, 0, S_OLD, 0, 0); // first req
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 3'd4,  1, 2'd0, 0, S_INC, 1, 0); // ack + back-to-back
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 3'd4,  1, 2'd1, 0, S_INC, 1, 0); // second ack hits limit
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 3'd4,  0, 2'd2, 1, S_OLD, 0, 0); // peak 2, beat 1
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 3'd4,  1, 2'd1, 1, S_OLD, 0, 0); // beat 2
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 3'd1,  1, 2'd0, 0, S_INC, 1, 0); // ack, credits 1
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 3'd1,  0, 2'd1, 0, S_OLD, 0, 0); // credit stall
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 3'd1,  0, 2'd1, 0, S_OLD, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 3'd2,  0, 2'd1, 0, S_OLD, 0, 0); // credits return
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 3'd4,  1, 2'd1, 0, S_INC, 1, 0); // req rose, acked
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 3'd4,  0, 2'd2, 0, S_BRN, 1, 1); // branch with 2 out
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 3'd4,  0, 2'd2, 0, S_OLD, 0, 0); // stale beat 1
    tbl[13] = mk(0, 1, 0, 0, 0, 0, 3'd4,  1, 2'd1, 0, S_OLD, 0, 0); // stale beat 2
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 3'd4,  1, 2'd0, 0, S_INC, 1, 0);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 3'd4,  1, 2'd1, 1, S_OLD, 0, 0); // third beat passes
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 3'd4,  1, 2'd0, 0, S_INC, 1, 0);
    tbl[17] = mk(1, 1, 1, 0, 0, 0, 3'd4,  1, 2'd1, 0, S_ISR, 1, 1); // except+ack+valid
    tbl[18] = mk(0, 1, 0, 0, 0, 0, 3'd4,  1, 2'd1, 0, S_OLD, 0, 0); // acked-old beat dropped
    tbl[19] = mk(1, 0, 1, 1, 1, 0, 3'd4,  1, 2'd0, 0, S_ISR, 1, 1); // all redirects at once
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 3'd4,  1, 2'd1, 0, S_INC, 1, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 1, 3'd4,  0, 2'd2, 0, S_OLD, 0, 0); // out=2 cancel=1, stall
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 3'd4,  0, 2'd0, 0, S_OLD, 0, 0); // after mid-flight reset
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 3'd4,  1, 2'd0, 0, S_OLD, 0, 0);
    tbl[24] = mk(1, 0, 0, 0, 0, 0, 3'd4,  1, 2'd0, 0, S_INC, 1, 0);
    tbl[25] = mk(0, 1, 0, 0, 0, 0, 3'd4,  1, 2'd1, 1, S_OLD, 0, 0); // cancel was cleared
    tbl[26] = mk(0, 0, 0, 1, 1, 0, 3'd4,  1, 2'd0, 0, S_ERT, 1, 1); // ertn beats branch

    drive_idle();
    resetn = 1'b0;
    @(negedge clk);
    check_reset(-1);
    resetn = 1'b1;

    for (int i = 0; i <= 21; i++) run_row(i);

    // Mid-flight reset: state must clear without waiting for a clock edge.
    #1;
    drive_idle();
    #1;
    resetn = 1'b0;
    #1;
    check_reset(-2);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 22; i < NROW; i++) run_row(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/c7bifu_fcl_mo.md
# c7bifu_fcl_mo

Multi-outstanding fetch control for the c7bifu front end. Sits between the prefetch address register/instruction queue and the ICU request port. Keeps up to MAX_OUTSTANDING ICU fetches in flight, gates issue on instruction-queue credits, and redirects on except/branch/ertn. It tracks how many in-flight responses a flush has made stale and suppresses exactly that many.

## Interface
- MAX_OUTSTANDING, 2: maximum number of acked requests whose data has not yet returned. Legal range is 1..7.
- IQ_DEPTH, 4: number of instruction-queue entries.
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of the outstanding and cancel counters (derived).
- IQ_CNT_W, $clog2(IQ_DEPTH+1): width of iq_free (derived).
- clk  in  1  single clock.
- resetn  in  1  reset, asynchronous, active-low.
- ifu_icu_req_ic1  out  1  registered fetch request; held until ack.
- icu_ifu_ack_ic1  in  1  request accepted; the ICU samples the prefetch address in this cycle.
- icu_ifu_data_valid_ic2  in  1  one response beat, returned in order.
- exu_ifu_except / exu_ifu_branch / exu_ifu_ertn  in  1 each  redirect requests.
- exu_ifu_stall  in  1  passed through to stall.
- iq_free  in  IQ_CNT_W  free IQ entries, registered by the IQ.
- pf_addr_sel_init/old/inc/brn/isr/ert  out  1 each  one-hot select for the prefetch address mux.
- pf_addr_en  out  1  prefetch address register load enable.
- icu_data_vld  out  1  response is live; the IQ writes it.
- stall  out  1  equals exu_ifu_stall.
- flush  out  1  except | branch | ertn.
- outst_cnt  out  CNT_W  acked requests awaiting data (debug).

## Operation
- rst_done register: resets to 0 and loads 1 on the first clock edge after resetn rises.
- Next-state values:
  - out_nxt = out_cnt + ack − valid.
  - cancel_nxt = flush ? out_nxt : cancel_cnt − (valid & cancel_cnt≠0).
  - live_nxt = out_nxt − cancel_nxt.
- issue = rst_done & ~(req_q & ~ack) & (out_nxt < MAX_OUTSTANDING) & (iq_free > live_nxt).
  - A flush does not bypass the limit. Cancelled beats still occupy slots but not credits.
- req_q_nxt = (req_q & ~ack) | issue.
  - Back-to-back issue is allowed in the cycle of an ack.
- Response gating: icu_data_vld = valid & (cancel_cnt==0) & ~flush.
  - A valid beat with cancel_cnt≠0 is dropped and decrements cancel_cnt.
- Redirect during a pending unacked request: the request stays asserted. It fetches the redirected address because the ICU samples the address at ack. It is not cancelled.
- Flush and ack in the same cycle: the acked fetch used the old address, so it is counted in cancel_nxt.
- Flush and valid in the same cycle: that beat is dropped and is not counted in cancel_nxt.
- Address select priority: init > isr (except) > ert (ertn) > brn (branch) > inc > old. Exactly one select is high.
  - init = ~rst_done.
  - inc = ack & ~flush & rst_done.
  - old = none of the above.
- pf_addr_en = init | flush | inc.
- Protocol error: valid with out_cnt==0, or ack with out_cnt==MAX_OUTSTANDING. Simulation asserts fire; counters saturate and do not wrap.

## Timing
- Reset values:
  - ifu_icu_req_ic1=0, outst_cnt=0, cancel_cnt=0, rst_done=0, icu_data_vld=0.
  - pf_addr_sel_init=1, pf_addr_en=1.
- The first request is asserted 2 cycles after resetn deasserts, provided iq_free>0.
- Issue latency: issue in cycle N gives ifu_icu_req_ic1 high in N+1.
- The address advances (inc) in the ack cycle, so the next request presents PC+4.
- icu_data_vld is combinational from valid, with zero latency.
- Counter updates take effect on the next edge.
- Asserting resetn low mid-operation clears all state immediately; in-flight responses after reset are a protocol error.

## Structure
- Package c7bifu_pkg holds the address-select index localparams (SEL_INIT..SEL_ERT) and the CNT_W helper function.
- One sub-module, c7bifu_updn_cnt: a parametrised saturating up/down counter with a synchronous load. It is instantiated for outst_cnt and cancel_cnt.
- Flops use the codebase dffrl_ns/dffrle_ns cells.

## Test plan
- Reset and back-to-back fetch:
  - Stimulus: MAX_OUTSTANDING=2, iq_free=4, ack 1 cycle after each req, valid 2 cycles after each ack.
  - Response: req at cycle 2 and again in the ack cycle; outst_cnt peaks at 2; icu_data_vld on every beat; sel_inc on each ack.
- Credit stall:
  - Stimulus: iq_free=1 with one live fetch outstanding.
  - Response: req stays 0. It rises the cycle after iq_free becomes 2.
- Flush with 2 outstanding:
  - Stimulus: branch pulse while outst_cnt=2.
  - Response: sel_brn=1 and pf_addr_en=1; cancel_cnt=2; the next 2 valid beats give icu_data_vld=0; the third beat is passed.
- Flush coincident with ack and valid:
  - Stimulus: out_cnt=1; except, ack and valid in the same cycle.
  - Response: the valid beat is dropped; cancel_cnt=1; sel_isr wins over inc.
- Simultaneous except, ertn and branch:
  - Response: only sel_isr is high; flush=1.
- Reset mid-flight:
  - Stimulus: resetn low while outst_cnt=2 and cancel_cnt=1.
  - Response: all counters go to 0 immediately; sel_init=1; req=0.
